// File: rtl/ad_envelope.sv
// ad_envelope -- attack/decay envelope generator with built-in VCA.
//
// A rising edge of sample_clk (seen in the clk domain) is a "tick". On each
// tick the block latches its sample inputs, updates the gate comparator,
// the envelope state machine and the end-of-cycle flag. The sample outputs
// are refreshed one clk later and then hold until the next tick.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   sample_clk   sample strobe level (synchronous to clk)
//   sample_in0   gate / trigger CV (signed)
//   sample_in1   audio input to the VCA (signed)
//   sample_in2   attack-rate CV (signed, negative treated as 0)
//   sample_in3   decay-rate CV (signed, negative treated as 0)
//   jack         jack-insertion flags, bit 0 = in0 cable present
//   sample_out0  envelope level 0..32767
//   sample_out1  VCA output: (in1 * env) >>> 15
//   sample_out2  gate monitor (20000 / 0)
//   sample_out3  end-of-cycle pulse (20000 for one sample / 0)
module ad_envelope #(
    parameter int W          = 16,
    parameter int GATE_ON    = 4000,
    parameter int GATE_OFF   = 2000,
    parameter int RATE_SHIFT = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sample_clk,
    input  logic signed [W-1:0] sample_in0,
    input  logic signed [W-1:0] sample_in1,
    input  logic signed [W-1:0] sample_in2,
    input  logic signed [W-1:0] sample_in3,
    input  logic [7:0]          jack,
    output logic signed [W-1:0] sample_out0,
    output logic signed [W-1:0] sample_out1,
    output logic signed [W-1:0] sample_out2,
    output logic signed [W-1:0] sample_out3
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ATTACK = 2'd1,
        DECAY  = 2'd2
    } state_t;

    // Envelope arithmetic is two bits wider than a sample so that
    // env + rate can never wrap and env - rate keeps a sign bit.
    localparam int EW = W + 2;

    localparam logic signed [W-1:0]  GATE_ON_S  = W'(GATE_ON);
    localparam logic signed [W-1:0]  GATE_OFF_S = W'(GATE_OFF);
    localparam logic        [EW-1:0] ENV_MAX_X  = EW'(32767);
    localparam logic        [15:0]   ENV_MAX    = 16'd32767;
    localparam logic signed [W-1:0]  MON_HIGH   = W'(20000);

    logic                sample_clk_reg;
    logic                tick;
    logic                tick_reg;

    logic signed [W-1:0] in0_reg;
    logic signed [W-1:0] in1_reg;
    logic signed [W-1:0] in2_reg;
    logic signed [W-1:0] in3_reg;
    logic [7:0]          jack_reg;

    state_t              state_reg;
    state_t              state_next;
    logic [15:0]         env_reg;
    logic [15:0]         env_next;
    logic                gate_reg;
    logic                gate_next;
    logic                eoc_reg;
    logic                eoc_next;

    logic [W-1:0]        rate_a;
    logic [W-1:0]        rate_d;
    logic [EW-1:0]       env_sum;
    logic signed [EW-1:0] env_diff;
    logic                gate_rise;
    logic                decay_zero;

    logic signed [2*W-1:0] vca_prod;
    logic signed [2*W-1:0] vca_shift;
    logic                  unused_bits;

    assign tick = sample_clk & ~sample_clk_reg;

    // 1 + (max(cv,0) >> RATE_SHIFT): a zero rate would stall the envelope.
    function automatic logic [W-1:0] rate_of(input logic signed [W-1:0] cv);
        logic [W-1:0] mag;
        mag = cv[W-1] ? '0 : $unsigned(cv);
        return (mag >> RATE_SHIFT) + W'(1);
    endfunction

    assign rate_a     = rate_of(sample_in2);
    assign rate_d     = rate_of(sample_in3);
    assign env_sum    = EW'(env_reg) + EW'(rate_a);
    assign env_diff   = $signed(EW'(env_reg)) - $signed(EW'(rate_d));
    assign decay_zero = env_diff[EW-1] | (env_diff == '0);

    // Gate comparator with hysteresis; an unplugged in0 jack forces it low.
    always_comb begin
        gate_next = gate_reg;
        if (!jack[0]) begin
            gate_next = 1'b0;
        end else if (sample_in0 > GATE_ON_S) begin
            gate_next = 1'b1;
        end else if (sample_in0 < GATE_OFF_S) begin
            gate_next = 1'b0;
        end
    end

    assign gate_rise = gate_next & ~gate_reg;

    // Envelope next-state logic. Only applied on ticks.
    always_comb begin
        state_next = state_reg;
        env_next   = env_reg;
        eoc_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                env_next = '0;
                if (gate_rise) begin
                    state_next = ATTACK;
                end
            end
            ATTACK: begin
                // Retriggers are ignored while still rising.
                if (env_sum >= ENV_MAX_X) begin
                    env_next   = ENV_MAX;
                    state_next = DECAY;
                end else begin
                    env_next = 16'(env_sum);
                end
            end
            DECAY: begin
                if (decay_zero) begin
                    env_next = '0;
                    if (gate_rise) begin
                        // Retrigger beats end-of-cycle: restart from zero.
                        state_next = ATTACK;
                    end else begin
                        state_next = IDLE;
                        eoc_next   = 1'b1;
                    end
                end else if (gate_rise) begin
                    // Retrigger: keep the level, attack resumes next tick.
                    state_next = ATTACK;
                end else begin
                    env_next = 16'(env_diff);
                end
            end
            default: begin
                state_next = IDLE;
                env_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_clk_reg <= 1'b0;
            tick_reg       <= 1'b0;
            in0_reg        <= '0;
            in1_reg        <= '0;
            in2_reg        <= '0;
            in3_reg        <= '0;
            jack_reg       <= '0;
            state_reg      <= IDLE;
            env_reg        <= '0;
            gate_reg       <= 1'b0;
            eoc_reg        <= 1'b0;
        end else begin
            sample_clk_reg <= sample_clk;
            tick_reg       <= tick;
            if (tick) begin
                in0_reg   <= sample_in0;
                in1_reg   <= sample_in1;
                in2_reg   <= sample_in2;
                in3_reg   <= sample_in3;
                jack_reg  <= jack;
                state_reg <= state_next;
                env_reg   <= env_next;
                gate_reg  <= gate_next;
                eoc_reg   <= eoc_next;
            end
        end
    end

    // VCA: full signed 2W-bit product, arithmetic shift, keep low W bits.
    assign vca_prod  = $signed({{W{in1_reg[W-1]}}, in1_reg}) * $signed((2 * W)'(env_reg));
    assign vca_shift = vca_prod >>> 15;

    // Latched copies that no downstream logic consumes are kept for
    // observability only.
    assign unused_bits = ^{in0_reg, in2_reg, in3_reg, jack_reg, vca_shift[2*W-1:W]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_out0 <= '0;
            sample_out1 <= '0;
            sample_out2 <= '0;
            sample_out3 <= '0;
        end else if (tick_reg) begin
            sample_out0 <= W'(env_reg);
            sample_out1 <= vca_shift[W-1:0];
            sample_out2 <= gate_reg ? MON_HIGH : '0;
            sample_out3 <= eoc_reg ? MON_HIGH : '0;
        end
    end

endmodule

// File: tb/tb_ad_envelope.sv
// Directed testbench for ad_envelope: a vector table for the gate
// hysteresis / early attack, then hand-written sequences for clamping,
// retrigger, jack removal, reset and full decay with end-of-cycle.
module tb_ad_envelope;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               sample_clk = 1'b0;
    logic signed [15:0] sample_in0 = '0;
    logic signed [15:0] sample_in1 = '0;
    logic signed [15:0] sample_in2 = '0;
    logic signed [15:0] sample_in3 = '0;
    logic [7:0]         jack = 8'h01;
    logic signed [15:0] sample_out0;
    logic signed [15:0] sample_out1;
    logic signed [15:0] sample_out2;
    logic signed [15:0] sample_out3;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        int in0;
        int in1;
        int in2;
        int in3;
        int jk;
        int e0;
        int e1;
        int e2;
        int e3;
    } vec_t;

    vec_t vecs[6];

    ad_envelope dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_clk  (sample_clk),
        .sample_in0  (sample_in0),
        .sample_in1  (sample_in1),
        .sample_in2  (sample_in2),
        .sample_in3  (sample_in3),
        .jack        (jack),
        .sample_out0 (sample_out0),
        .sample_out1 (sample_out1),
        .sample_out2 (sample_out2),
        .sample_out3 (sample_out3)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One sample period = 2 clk cycles; returns 1 ns after the output update.
    task automatic drive_tick(input int a0, input int a1, input int a2, input int a3, input int j);
        @(negedge clk);
        sample_in0 = 16'(a0);
        sample_in1 = 16'(a1);
        sample_in2 = 16'(a2);
        sample_in3 = 16'(a3);
        jack       = 8'(j);
        sample_clk = 1'b1;
        @(negedge clk);
        sample_clk = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input int e0, input int e1, input int e2, input int e3);
        check({tag, ".out0"}, int'(sample_out0), e0);
        check({tag, ".out1"}, int'(sample_out1), e1);
        check({tag, ".out2"}, int'(sample_out2), e2);
        check({tag, ".out3"}, int'(sample_out3), e3);
        $display("tick %s: out0=%0d out1=%0d out2=%0d out3=%0d", tag,
                 sample_out0, sample_out1, sample_out2, sample_out3);
    endtask

    initial begin
        int env;
        // in1=20000, rate_a=rate_d=512; hysteresis pattern 5000,3000,3000,1000,3000,5000
        vecs[0] = '{5000, 20000, 32767, 32767, 1,    0,    0, 20000, 0};
        vecs[1] = '{3000, 20000, 32767, 32767, 1,  512,  312, 20000, 0};
        vecs[2] = '{3000, 20000, 32767, 32767, 1, 1024,  625, 20000, 0};
        vecs[3] = '{1000, 20000, 32767, 32767, 1, 1536,  937,     0, 0};
        vecs[4] = '{3000, 20000, 32767, 32767, 1, 2048, 1250,     0, 0};
        vecs[5] = '{5000, 20000, 32767, 32767, 1, 2560, 1562, 20000, 0};

        repeat (3) @(posedge clk);
        #1;
        check_all("reset", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            drive_tick(vecs[i].in0, vecs[i].in1, vecs[i].in2, vecs[i].in3, vecs[i].jk);
            check_all($sformatf("vec%0d", i), vecs[i].e0, vecs[i].e1, vecs[i].e2, vecs[i].e3);
        end

        // Attack continues to the clamp at 64*512 -> 32767.
        for (int k = 6; k <= 64; k++) begin
            drive_tick(5000, 20000, 32767, 32767, 1);
            env = (k * 512 > 32767) ? 32767 : k * 512;
            check($sformatf("attack512_k%0d", k), int'(sample_out0), env);
            if (k == 32) check("vca_half", int'(sample_out1), 10000);
        end

        // Decay, falling gate has no effect, retrigger keeps the level.
        drive_tick(5000, 20000, 32767, 32767, 1);
        check_all("decay1", 32255, 19686, 20000, 0);
        drive_tick(1000, 20000, 32767, 32767, 1);
        check_all("gate_fall", 31743, 19374, 0, 0);
        drive_tick(5000, 20000, 32767, 32767, 1);
        check_all("retrigger", 31743, 19374, 20000, 0);
        drive_tick(5000, 20000, 32767, 32767, 1);
        check("resume_attack", int'(sample_out0), 32255);
        // Jack pulled mid-envelope: gate drops, envelope keeps going.
        drive_tick(5000, 20000, 32767, 32767, 0);
        check("jack_out.out2", int'(sample_out2), 0);
        check("jack_out.out0", int'(sample_out0), 32767);
        drive_tick(5000, 20000, 32767, 32767, 0);
        check("jack_out_decay", int'(sample_out0), 32255);

        // Fresh start with rate_a = 100, reset mid-attack.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all("reset2", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive_tick(0, -32768, 6336, 0, 1);
        check_all("idle_low", 0, 0, 0, 0);
        drive_tick(5000, -32768, 6336, 0, 1);
        check_all("trig100", 0, 0, 20000, 0);
        for (int i = 1; i <= 3; i++) begin
            drive_tick(5000, -32768, 6336, 0, 1);
            check($sformatf("pre_reset_i%0d", i), int'(sample_out0), 100 * i);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all("reset_mid_attack", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive_tick(5000, -32768, 6336, 0, 1);
        check_all("retrig_after_reset", 0, 0, 20000, 0);
        for (int i = 1; i <= 328; i++) begin
            drive_tick(5000, -32768, 6336, 0, 1);
            env = (i * 100 > 32767) ? 32767 : i * 100;
            check($sformatf("attack100_i%0d", i), int'(sample_out0), env);
            check($sformatf("no_eoc_i%0d", i), int'(sample_out3), 0);
        end
        check("vca_full_neg", int'(sample_out1), -32767);

        // Decay at rate 1: 32767 ticks to zero, EOC on the last one only.
        for (int j = 1; j <= 32767; j++) begin
            drive_tick(5000, -32768, 6336, 0, 1);
            check($sformatf("decay1_j%0d", j), int'(sample_out0), 32767 - j);
            check($sformatf("eoc_j%0d", j), int'(sample_out3), (j == 32767) ? 20000 : 0);
        end
        drive_tick(5000, -32768, 6336, 0, 1);
        check_all("idle_after_eoc", 0, 0, 20000, 0);

        // Jack removed with in0 high: gate low, no trigger; reinsertion triggers.
        drive_tick(5000, 20000, 32767, 32767, 0);
        check_all("jack0_a", 0, 0, 0, 0);
        drive_tick(5000, 20000, 32767, 32767, 0);
        check_all("jack0_b", 0, 0, 0, 0);
        drive_tick(5000, 20000, 32767, 32767, 1);
        check_all("jack1_trig", 0, 0, 20000, 0);
        for (int k = 1; k <= 64; k++) begin
            drive_tick(5000, 20000, 32767, 32767, 1);
            env = (k * 512 > 32767) ? 32767 : k * 512;
            check($sformatf("attack_b_k%0d", k), int'(sample_out0), env);
        end
        for (int m = 1; m <= 63; m++) begin
            drive_tick(1000, 20000, 32767, 32767, 1);
            check($sformatf("decay512_m%0d", m), int'(sample_out0), 32767 - 512 * m);
        end
        // Retrigger on the same tick decay would reach zero: retrigger wins.
        drive_tick(5000, 20000, 32767, 32767, 1);
        check_all("retrig_vs_zero", 0, 0, 20000, 0);
        drive_tick(5000, 20000, 32767, 32767, 1);
        check("attack_after_tie", int'(sample_out0), 512);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
